// File: rtl/alu_issue_stage.sv
// Operand-issue and writeback stage for an 8-bit combinational ALU.
// Instructions arrive over valid/ready. Operands are read from an 8x8 register
// file, or forwarded from the result currently in EX. The registered EX slot
// drives the ALU. The ALU result is written back on the following edge, and
// results, illegal ops and a retired-instruction count are reported.
module alu_issue_stage #(
  parameter int unsigned NREGS = 8,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  // instruction handshake
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_op,
  input  logic [2:0]   in_rd,
  input  logic [2:0]   in_rs1,
  input  logic [2:0]   in_rs2,
  input  logic         in_use_imm,
  input  logic [W-1:0] in_imm,
  input  logic         hold,
  // ALU interface
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_out,
  // result reporting
  output logic         res_valid,
  output logic [2:0]   res_rd,
  output logic [W-1:0] res_data,
  output logic         err_illegal,
  output logic [15:0]  retired,
  // debug register read
  input  logic [2:0]   dbg_addr,
  output logic [W-1:0] dbg_data
);

  localparam logic [2:0] OpIllegal = 3'b111;

  // Register file. Entry 0 is reset and never written, so r0 always reads 0.
  logic [W-1:0] rf_q [NREGS];

  // EX slot
  logic         ex_valid_q;
  logic [2:0]   ex_op_q;
  logic [2:0]   ex_rd_q;
  logic [W-1:0] ex_a_q;
  logic [W-1:0] ex_b_q;

  // Writeback reporting
  logic         res_valid_q;
  logic [2:0]   res_rd_q;
  logic [W-1:0] res_data_q;
  logic         err_illegal_q;
  logic [15:0]  retired_q;

  logic         accept;
  logic         ex_legal;
  logic         fwd_en;
  logic         fwd_a;
  logic         fwd_b;
  logic [W-1:0] rf_rs1;
  logic [W-1:0] rf_rs2;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;

  // Handshake: ready only out of reset and when not stalled.
  always_comb begin
    in_ready = rst_n & ~hold;
    accept   = in_valid & in_ready;
  end

  // Operand selection. A source matching the EX destination takes alu_out,
  // because that value lands in the register file on the same edge.
  // Illegal ops and r0 writes produce nothing to forward.
  always_comb begin
    ex_legal = (ex_op_q != OpIllegal);
    fwd_en   = ex_valid_q & ex_legal & (ex_rd_q != 3'd0);
    fwd_a    = fwd_en & (in_rs1 == ex_rd_q);
    fwd_b    = fwd_en & (in_rs2 == ex_rd_q);
    rf_rs1   = (in_rs1 == 3'd0) ? '0 : rf_q[in_rs1];
    rf_rs2   = (in_rs2 == 3'd0) ? '0 : rf_q[in_rs2];
    op_a     = fwd_a ? alu_out : rf_rs1;
    if (in_use_imm) begin
      op_b = in_imm;
    end else begin
      op_b = fwd_b ? alu_out : rf_rs2;
    end
  end

  // EX slot. The operand fields hold their last values when nothing is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_op_q    <= '0;
      ex_rd_q    <= '0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
    end else begin
      ex_valid_q <= accept;
      if (accept) begin
        ex_op_q <= in_op;
        ex_rd_q <= in_rd;
        ex_a_q  <= op_a;
        ex_b_q  <= op_b;
      end
    end
  end

  // Retire the EX instruction: write back, report, and count.
  // alu_out is not sampled for the illegal op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        rf_q[i] <= '0;
      end
      res_valid_q   <= 1'b0;
      res_rd_q      <= '0;
      res_data_q    <= '0;
      err_illegal_q <= 1'b0;
      retired_q     <= '0;
    end else begin
      res_valid_q   <= 1'b0;
      err_illegal_q <= 1'b0;
      if (ex_valid_q) begin
        retired_q <= retired_q + 16'd1;
        if (ex_legal) begin
          res_valid_q <= 1'b1;
          res_rd_q    <= ex_rd_q;
          res_data_q  <= alu_out;
          if (ex_rd_q != 3'd0) begin
            rf_q[ex_rd_q] <= alu_out;
          end
        end else begin
          err_illegal_q <= 1'b1;
        end
      end
    end
  end

  // Output drive. The debug read shows the pre-edge value of a register
  // that is being written.
  always_comb begin
    alu_a       = ex_a_q;
    alu_b       = ex_b_q;
    alu_op      = ex_op_q;
    res_valid   = res_valid_q;
    res_rd      = res_rd_q;
    res_data    = res_data_q;
    err_illegal = err_illegal_q;
    retired     = retired_q;
    dbg_data    = (dbg_addr == 3'd0) ? '0 : rf_q[dbg_addr];
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed testbench for alu_issue_stage. It contains a behavioural ALU model
// and hand-computed expected values.
module tb_alu_issue_stage;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [2:0] in_rd;
  logic [2:0] in_rs1;
  logic [2:0] in_rs2;
  logic       in_use_imm;
  logic [7:0] in_imm;
  logic       hold;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_out;
  logic       res_valid;
  logic [2:0] res_rd;
  logic [7:0] res_data;
  logic       err_illegal;
  logic [15:0] retired;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_data;

  int checks;
  int errors;

  alu_issue_stage #(
    .NREGS(8),
    .W    (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_use_imm (in_use_imm),
    .in_imm     (in_imm),
    .hold       (hold),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_out    (alu_out),
    .res_valid  (res_valid),
    .res_rd     (res_rd),
    .res_data   (res_data),
    .err_illegal(err_illegal),
    .retired    (retired),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model. Op 7 gets a poison value, so any write or forward of it shows up.
  always_comb begin
    alu_out = 8'h00;
    case (alu_op)
      3'd0:    alu_out = alu_a + alu_b;
      3'd1:    alu_out = alu_a - alu_b;
      3'd2:    alu_out = alu_a & alu_b;
      3'd3:    alu_out = alu_a | alu_b;
      3'd4:    alu_out = alu_a ^ alu_b;
      3'd5:    alu_out = alu_a << 1;
      3'd6:    alu_out = alu_a >> 1;
      default: alu_out = 8'hAA;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic use_imm, input logic [7:0] imm);
    in_op      = op;
    in_rd      = rd;
    in_rs1     = rs1;
    in_rs2     = rs2;
    in_use_imm = use_imm;
    in_imm     = imm;
    in_valid   = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic dbg_check(input string tag, input logic [2:0] addr, input logic [7:0] exp);
    dbg_addr = addr;
    #1;
    check(tag, {24'd0, dbg_data}, {24'd0, exp});
  endtask

  task automatic res_check(input string tag, input logic [2:0] rd, input logic [7:0] data);
    check({tag, ".valid"}, {31'd0, res_valid}, 32'd1);
    check({tag, ".rd"}, {29'd0, res_rd}, {29'd0, rd});
    check({tag, ".data"}, {24'd0, res_data}, {24'd0, data});
  endtask

  initial begin
    int n_wrap;
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_op      = 3'd0;
    in_rd      = 3'd0;
    in_rs1     = 3'd0;
    in_rs2     = 3'd0;
    in_use_imm = 1'b0;
    in_imm     = 8'h00;
    hold       = 1'b0;
    dbg_addr   = 3'd0;

    // Reset state
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst.in_ready", {31'd0, in_ready}, 32'd0);
    check("rst.res_valid", {31'd0, res_valid}, 32'd0);
    check("rst.err", {31'd0, err_illegal}, 32'd0);
    check("rst.retired", {16'd0, retired}, 32'd0);
    check("rst.alu", {13'd0, alu_a, alu_b, alu_op}, 32'd0);
    check("rst.res", {21'd0, res_rd, res_data}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst.in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 8; i++) dbg_check("rst.dbg", 3'(i), 8'h00);

    // r1 = r0 + 5, then r2 = r1 + r1 with both operands forwarded
    issue(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 8'h05);
    issue(3'd0, 3'd2, 3'd1, 3'd1, 1'b0, 8'h00);
    res_check("add_imm", 3'd1, 8'h05);
    tick();
    res_check("add_fwd", 3'd2, 8'h0A);
    dbg_check("dbg_r2", 3'd2, 8'h0A);
    check("retired_2", {16'd0, retired}, 32'd2);

    // Wraparound add and subtract
    issue(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 8'hFF);
    issue(3'd0, 3'd3, 3'd1, 3'd0, 1'b1, 8'h02);
    check("fwd.alu_a", {24'd0, alu_a}, 32'hFF);
    check("fwd.alu_b", {24'd0, alu_b}, 32'h02);
    issue(3'd1, 3'd4, 3'd0, 3'd1, 1'b0, 8'h00);
    res_check("add_wrap", 3'd3, 8'h01);
    check("sub.alu_b", {24'd0, alu_b}, 32'hFF);
    tick();
    res_check("sub", 3'd4, 8'h01);
    check("hold_alu_op", {29'd0, alu_op}, 32'd1);

    // Shift and logic on r1 = 0x81
    issue(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 8'h81);
    issue(3'd5, 3'd2, 3'd1, 3'd0, 1'b0, 8'h00);
    res_check("r1_81", 3'd1, 8'h81);
    issue(3'd6, 3'd3, 3'd1, 3'd0, 1'b0, 8'h00);
    res_check("shl", 3'd2, 8'h02);
    issue(3'd4, 3'd4, 3'd1, 3'd0, 1'b1, 8'hFF);
    res_check("shr", 3'd3, 8'h40);
    tick();
    res_check("xor", 3'd4, 8'h7E);
    check("retired_9", {16'd0, retired}, 32'd9);

    // Illegal op to r5. The following r5 reader must not take the poison value.
    issue(3'd0, 3'd5, 3'd0, 3'd0, 1'b1, 8'h3C);
    issue(3'd7, 3'd5, 3'd0, 3'd0, 1'b1, 8'h11);
    res_check("r5_set", 3'd5, 8'h3C);
    issue(3'd0, 3'd6, 3'd5, 3'd0, 1'b1, 8'h00);
    check("ill.err", {31'd0, err_illegal}, 32'd1);
    check("ill.res_valid", {31'd0, res_valid}, 32'd0);
    check("ill.retired", {16'd0, retired}, 32'd11);
    dbg_check("ill.r5", 3'd5, 8'h3C);
    tick();
    check("ill.err_once", {31'd0, err_illegal}, 32'd0);
    res_check("ill.nofwd", 3'd6, 8'h3C);

    // EX retires under hold; held offers are not accepted
    issue(3'd0, 3'd7, 3'd0, 3'd0, 1'b1, 8'h09);
    hold     = 1'b1;
    in_valid = 1'b1;
    in_imm   = 8'h77;
    #1;
    check("hold.ready", {31'd0, in_ready}, 32'd0);
    tick();
    res_check("hold.retire", 3'd7, 8'h09);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("hold.ready_n", {31'd0, in_ready}, 32'd0);
      check("hold.no_res", {31'd0, res_valid}, 32'd0);
    end
    check("hold.retired", {16'd0, retired}, 32'd13);
    in_valid = 1'b0;
    hold     = 1'b0;

    // Write to r0 is reported but discarded and never forwarded
    issue(3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 8'h55);
    issue(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 8'h01);
    res_check("r0_write", 3'd0, 8'h55);
    tick();
    res_check("r0_nofwd", 3'd1, 8'h01);
    dbg_check("r0_zero", 3'd0, 8'h00);
    check("retired_15", {16'd0, retired}, 32'd15);

    // Retired counter wrap: back-to-back stream until the count reaches 0x10000
    n_wrap     = 65536 - 15;
    in_op      = 3'd0;
    in_rd      = 3'd1;
    in_rs1     = 3'd0;
    in_use_imm = 1'b1;
    in_imm     = 8'h01;
    in_valid   = 1'b1;
    repeat (n_wrap) tick();
    check("wrap.ffff", {16'd0, retired}, 32'hFFFF);
    in_valid = 1'b0;
    tick();
    check("wrap.zero", {16'd0, retired}, 32'd0);

    // Reset with an instruction in EX drops it
    issue(3'd0, 3'd6, 3'd0, 3'd0, 1'b1, 8'h33);
    rst_n = 1'b0;
    #1;
    check("mid_rst.ready", {31'd0, in_ready}, 32'd0);
    check("mid_rst.alu", {13'd0, alu_a, alu_b, alu_op}, 32'd0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("mid_rst.res_valid", {31'd0, res_valid}, 32'd0);
    check("mid_rst.retired", {16'd0, retired}, 32'd0);
    dbg_check("mid_rst.r6", 3'd6, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Operand-issue and writeback stage feeding the 8-bit combinational ALU (ops: add, sub, and, or, xor, shl1, shr1). It accepts instructions over a valid/ready handshake and reads operands from an internal 8x8 register file, forwarding from the in-flight result where needed. It drives the ALU operand and op inputs from a registered execute slot, captures the ALU result, and writes it back to the register file. It also reports results, illegal ops, and a retired-instruction count.

## Interface
- NREGS, 8: register count, fixed; indices are 3 bits.
- W, 8: data width; must match the ALU.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  stage can accept this cycle.
- in_op  in  3  ALU op code.
- in_rd  in  3  destination register.
- in_rs1  in  3  source A register.
- in_rs2  in  3  source B register.
- in_use_imm  in  1  1: operand B = in_imm; 0: B = reg[in_rs2].
- in_imm  in  8  immediate.
- hold  in  1  stall request; 1 forces in_ready=0.
- alu_a  out  8  ALU operand A (from EX slot).
- alu_b  out  8  ALU operand B (from EX slot).
- alu_op  out  3  ALU op (from EX slot).
- alu_out  in  8  ALU result, combinational from alu_a/alu_b/alu_op.
- res_valid  out  1  one-cycle pulse, result written back.
- res_rd  out  3  destination of reported result.
- res_data  out  8  written value.
- err_illegal  out  1  one-cycle pulse, op 3'b111 retired.
- retired  out  16  count of retired instructions, legal and illegal.
- dbg_addr  in  3  debug read index.
- dbg_data  out  8  combinational reg[dbg_addr]; r0 reads 0.

## Operation
- Register file: r0 is hardwired 0, and writes to r0 are discarded (still reported on res_*). r1–r7 reset to 0.
- in_ready = rst_n & ~hold. Accept = in_valid & in_ready.
- On accept:
  - The EX slot loads op, rd, and operand values A and B, and ex_valid is set.
  - If nothing is accepted, ex_valid clears on the next edge.
- Operand read happens at accept time:
  - A = reg[rs1].
  - B = in_use_imm ? in_imm : reg[rs2].
- Forwarding: if ex_valid, ex_op is legal, ex_rd != 0, and a source index equals ex_rd, that operand takes alu_out instead of the register file (the value being written the same edge). Immediates are never forwarded.
- alu_a, alu_b, alu_op are driven directly from the EX slot. When ex_valid=0 they hold their last values.
- Retire: on each edge with ex_valid=1, do the following:
  - Legal op (0–6): reg[ex_rd] <= alu_out (unless rd=0). Next cycle res_valid=1, res_rd=ex_rd, res_data=alu_out.
  - Op 3'b111: no register write, res_valid stays 0. Next cycle err_illegal=1, and the ALU's Z output is never sampled.
  - retired increments by 1 in both cases and wraps 0xFFFF -> 0x0000.
- hold while an instruction is in EX does not stall it: EX always retires on the next edge.
- Arithmetic is modulo 2^8; carry and borrow are discarded (ALU-defined).

## Timing
- Latency: accept at edge N, ALU operates during cycle N..N+1, register write and res_valid/err_illegal registered at edge N+1 (visible in cycle N+1..N+2).
- Throughput: one instruction per cycle; back-to-back dependent instructions need no stall thanks to forwarding.
- Reset (async assert, sync-released by the system) sets:
  - ex_valid=0, res_valid=0, err_illegal=0, res_rd=0, res_data=0, retired=0, all registers 0.
  - alu_a=0, alu_b=0, alu_op=0.
  - in_ready=0 while rst_n=0.
- Reset mid-operation: the in-flight EX instruction is dropped, with no write and no count.
- Simultaneous events:
  - Accept and retire on the same edge are normal pipeline overlap.
  - A debug read of the register being written returns the old value until the edge.

## Test plan
- Reset: rst_n=0 mid-stream -> all outputs 0, in_ready=0, retired=0; after release, dbg reads 0 for r0–r7.
- Immediate add then dependent add: (r1 = r0 + imm 0x05) then next cycle (r2 = r1 + r1) -> res_data 0x05 then 0x0A; dbg r2=0x0A (forwarding).
- Wraparound and sub: r1=0xFF (imm), then r3 = r1 + imm 0x02 -> 0x01; r4 = r0 - r1 -> 0x01.
- Shift/logic: r1=0x81, shl -> 0x02, shr -> 0x40, xor with imm 0xFF -> 0x7E.
- Illegal op 3'b111 to r5: err_illegal pulses once, res_valid=0, r5 unchanged, retired incremented.
- Handshake: hold=1 with in_valid=1 for 3 cycles -> in_ready=0, no accept, no count; write to r0 -> res_valid=1 but dbg r0=0; 65536 retires -> retired wraps to 0.
